pc_sequencer: RTL and testbench

Control block for the 8-bit program counter. It drives the PC's next-address select and jump address so the PC can be reset to a vector, redirected by branches, held on stalls and stopped on halt. It also issues fetch-valid and pipeline-flush indications to the fetch and decode stages. The PC has no enable or reset of its own, so this block implements every hold and every reset by steering the PC's jump mux.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: address width and the sequencer state encoding.
// The PC uses ADDR_W as well, so both blocks agree on address size.
package pc_sequencer_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer (slave side) and the CPU datapath (master side).
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic [ADDR_W-1:0] pc_in;
  logic              stall_in;
  logic              branch_req_in;
  logic [ADDR_W-1:0] branch_addr_in;
  logic              halt_in;
  logic              mux_sel_out;
  logic [ADDR_W-1:0] addr_to_jmp_out;
  logic              fetch_valid_out;
  logic              flush_out;
  logic [7:0]        branch_count_out;
  logic [1:0]        state_out;

  modport slave (
    input  pc_in, stall_in, branch_req_in, branch_addr_in, halt_in,
    output mux_sel_out, addr_to_jmp_out, fetch_valid_out, flush_out,
    branch_count_out, state_out
  );

  modport master (
    output pc_in, stall_in, branch_req_in, branch_addr_in, halt_in,
    input  mux_sel_out, addr_to_jmp_out, fetch_valid_out, flush_out,
    branch_count_out, state_out
  );

endinterface

// File: rtl/pc_sequencer.sv
// PC control FSM: steers the PC jump mux for reset, branch, stall and halt,
// and flags fetch validity / pipeline flush to the front end.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  pc_sequencer_if.slave  bus
);

  // Counter is preloaded with the number of flush cycles still to come after the first.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic [7:0]        branch_cnt_q, branch_cnt_d;

  logic              mux_sel;
  logic [ADDR_W-1:0] jmp_addr;
  logic              fetch_valid;
  logic              flush;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_BOOT;
      flush_cnt_q  <= 2'd0;
      branch_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    branch_cnt_d = branch_cnt_q;
    mux_sel      = 1'b0;
    jmp_addr     = bus.pc_in;
    fetch_valid  = 1'b0;
    flush        = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;

      ST_RUN: begin
        if (bus.halt_in) begin
          mux_sel = 1'b1;
          state_d = ST_HALT;
        end else if (bus.branch_req_in) begin
          mux_sel      = 1'b1;
          jmp_addr     = bus.branch_addr_in;
          branch_cnt_d = branch_cnt_q + 8'd1;
          flush_cnt_d  = FLUSH_LOAD;
          state_d      = ST_FLUSH;
        end else if (bus.stall_in) begin
          mux_sel = 1'b1;
        end else begin
          fetch_valid = 1'b1;
        end
      end

      ST_FLUSH: begin
        flush   = 1'b1;
        mux_sel = bus.stall_in;
        // Branch requests here come from squashed instructions and are dropped.
        if (bus.halt_in) begin
          state_d = ST_HALT;
        end else if (!bus.stall_in) begin
          if (flush_cnt_q == 2'd0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
      end

      ST_HALT: mux_sel = 1'b1;

      default: state_d = ST_BOOT;
    endcase

    // The PC has no reset of its own, so reset is delivered through the jump path.
    if (rst_in) begin
      mux_sel     = 1'b1;
      jmp_addr    = RESET_VECTOR;
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  assign bus.mux_sel_out      = mux_sel;
  assign bus.addr_to_jmp_out  = jmp_addr;
  assign bus.fetch_valid_out  = fetch_valid;
  assign bus.flush_out        = flush;
  assign bus.branch_count_out = branch_cnt_q;
  assign bus.state_out        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural PC plant plus a cycle model of the
// sequencer rules, exercised with directed scenarios and random traffic.
module tb_pc_sequencer;

  localparam logic [7:0] RV = 8'h10;
  localparam int         FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(RV), .FLUSH_CYCLES(FC)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: booting / halted flags, flush cycles still owed, branch tally, PC.
  bit         m_boot, m_halt, n_boot, n_halt;
  int         m_fr, n_fr;
  logic [7:0] m_cnt, n_cnt, m_pc, n_pc;
  bit         s_rst, s_stall, s_br, s_halt;
  logic [7:0] s_ba;
  logic       e_mux, e_fv, e_flush;
  logic [7:0] e_addr;
  logic [1:0] e_st;
  logic [20:0] act_v, exp_v;

  task model_eval();
    e_mux = 1'b0; e_addr = 8'h00; e_fv = 1'b0; e_flush = 1'b0; e_st = 2'd1;
    n_boot = m_boot; n_halt = m_halt; n_fr = m_fr; n_cnt = m_cnt;
    if (s_rst) begin
      e_mux = 1'b1; e_addr = RV;
      n_boot = 1; n_halt = 0; n_fr = 0; n_cnt = 8'h00;
    end else if (m_boot) begin
      e_st = 2'd0; n_boot = 0;
    end else if (m_halt) begin
      e_st = 2'd3; e_mux = 1'b1; e_addr = m_pc;
    end else if (m_fr > 0) begin
      e_st = 2'd2; e_flush = 1'b1; e_mux = s_stall; e_addr = m_pc;
      if (s_halt) n_halt = 1;
      else if (!s_stall) n_fr = m_fr - 1;
    end else begin
      e_st = 2'd1;
      if (s_halt) begin
        e_mux = 1'b1; e_addr = m_pc; n_halt = 1;
      end else if (s_br) begin
        e_mux = 1'b1; e_addr = s_ba; n_cnt = m_cnt + 8'd1; n_fr = FC;
      end else if (s_stall) begin
        e_mux = 1'b1; e_addr = m_pc;
      end else begin
        e_fv = 1'b1;
      end
    end
    n_pc = e_mux ? e_addr : m_pc + 8'd1;
  endtask

  task automatic drive(input bit r, input bit st, input bit br, input logic [7:0] ba, input bit h);
    s_rst = r; s_stall = st; s_br = br; s_ba = ba; s_halt = h;
    rst = r; bus.stall_in = st; bus.branch_req_in = br; bus.branch_addr_in = ba; bus.halt_in = h;
    #1;
    model_eval();
    act_v = {bus.mux_sel_out, e_mux ? bus.addr_to_jmp_out : 8'h00, bus.fetch_valid_out,
             bus.flush_out, bus.branch_count_out, s_rst ? 2'b00 : bus.state_out};
    exp_v = {e_mux, e_mux ? e_addr : 8'h00, e_fv, e_flush, m_cnt, s_rst ? 2'b00 : e_st};
    $display("cyc %0d rst=%b stall=%b br=%b ba=%h halt=%b | pc=%h mux=%b addr=%h fv=%b flush=%b cnt=%h state=%0d",
             cyc, r, st, br, ba, h, bus.pc_in, bus.mux_sel_out, bus.addr_to_jmp_out,
             bus.fetch_valid_out, bus.flush_out, bus.branch_count_out, bus.state_out);
  endtask

  task automatic tick();
    logic [7:0] nxt;
    nxt = bus.mux_sel_out ? bus.addr_to_jmp_out : bus.pc_in + 8'd1;
    @(posedge clk);
    #1;
    bus.pc_in = nxt;
    m_boot = n_boot; m_halt = n_halt; m_fr = n_fr; m_cnt = n_cnt; m_pc = n_pc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL reset outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.mux_sel_out !== 1'b1 || bus.addr_to_jmp_out !== 8'h10) begin
        n_fail++; $display("FAIL reset_vector: got mux=%b addr=%h want mux=1 addr=10", bus.mux_sel_out, bus.addr_to_jmp_out); end
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL boot outputs: got %h want %h", act_v, exp_v); end
    n_chk++; if (bus.state_out !== 2'd0 || bus.pc_in !== 8'h10 || bus.branch_count_out !== 8'h00) begin
      n_fail++; $display("FAIL boot_state: got state=%0d pc=%h cnt=%h want state=0 pc=10 cnt=00", bus.state_out, bus.pc_in, bus.branch_count_out); end
    tick();
    drive(0, 0, 0, 8'h00, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL first_run outputs: got %h want %h", act_v, exp_v); end
    n_chk++; if (bus.state_out !== 2'd1 || bus.fetch_valid_out !== 1'b1 || bus.pc_in !== 8'h11) begin
      n_fail++; $display("FAIL first_fetch: got state=%0d fv=%b pc=%h want state=1 fv=1 pc=11", bus.state_out, bus.fetch_valid_out, bus.pc_in); end
    tick();
  endtask

  task automatic test_branch();
    for (int g = 0; g < 64 && bus.pc_in !== 8'h20; g++) begin
      drive(0, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL run_idle outputs: got %h want %h", act_v, exp_v); end
      tick();
    end
    n_chk++; if (bus.pc_in !== 8'h20) begin n_fail++; $display("FAIL reach_20: got pc=%h want 20", bus.pc_in); end
    drive(0, 0, 1, 8'h80, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL branch outputs: got %h want %h", act_v, exp_v); end
    n_chk++; if (bus.mux_sel_out !== 1'b1 || bus.addr_to_jmp_out !== 8'h80) begin
      n_fail++; $display("FAIL branch_jump: got mux=%b addr=%h want mux=1 addr=80", bus.mux_sel_out, bus.addr_to_jmp_out); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL flush outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.flush_out !== 1'b1 || bus.pc_in !== 8'h80 + 8'(i)) begin
        n_fail++; $display("FAIL flush_window: got flush=%b pc=%h want flush=1 pc=%h", bus.flush_out, bus.pc_in, 8'h80 + 8'(i)); end
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL post_flush outputs: got %h want %h", act_v, exp_v); end
    n_chk++; if (bus.flush_out !== 1'b0 || bus.fetch_valid_out !== 1'b1 || bus.pc_in !== 8'h82 || bus.branch_count_out !== 8'h01) begin
      n_fail++; $display("FAIL target_fetch: got flush=%b fv=%b pc=%h cnt=%h want 0 1 82 01",
                         bus.flush_out, bus.fetch_valid_out, bus.pc_in, bus.branch_count_out); end
    tick();
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 8'h03, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall_setup outputs: got %h want %h", act_v, exp_v); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall_setup outputs: got %h want %h", act_v, exp_v); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.pc_in !== 8'h05 || bus.mux_sel_out !== 1'b1 || bus.addr_to_jmp_out !== 8'h05 || bus.fetch_valid_out !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got pc=%h mux=%b addr=%h fv=%b want 05 1 05 0",
                           bus.pc_in, bus.mux_sel_out, bus.addr_to_jmp_out, bus.fetch_valid_out); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall_release outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.pc_in !== 8'h05 + 8'(i) || bus.fetch_valid_out !== 1'b1) begin
        n_fail++; $display("FAIL stall_release: got pc=%h fv=%b want pc=%h fv=1", bus.pc_in, bus.fetch_valid_out, 8'h05 + 8'(i)); end
      tick();
    end
  endtask

  task automatic test_flush_stall();
    int fl_seen = 0;
    drive(0, 0, 1, 8'h30, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL flush_stall branch outputs: got %h want %h", act_v, exp_v); end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, i < 2, i < 4, 8'h99, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL flush_stall outputs: got %h want %h", act_v, exp_v); end
      if (bus.flush_out === 1'b1) fl_seen++;
      tick();
    end
    n_chk++; if (fl_seen !== 4) begin n_fail++; $display("FAIL flush_stretch: got %0d flush cycles want 4", fl_seen); end
    n_chk++; if (bus.branch_count_out !== 8'h03) begin n_fail++; $display("FAIL flush_ignore_branch: got cnt=%h want 03", bus.branch_count_out); end
  endtask

  task automatic test_halt();
    drive(0, 0, 1, 8'h3e, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halt_setup outputs: got %h want %h", act_v, exp_v); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halt_setup outputs: got %h want %h", act_v, exp_v); end
      tick();
    end
    drive(0, 0, 1, 8'h77, 1);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halt_entry outputs: got %h want %h", act_v, exp_v); end
    n_chk++; if (bus.pc_in !== 8'h40 || bus.mux_sel_out !== 1'b1 || bus.addr_to_jmp_out !== 8'h40) begin
      n_fail++; $display("FAIL halt_beats_branch: got pc=%h mux=%b addr=%h want 40 1 40", bus.pc_in, bus.mux_sel_out, bus.addr_to_jmp_out); end
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halted outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.state_out !== 2'd3 || bus.pc_in !== 8'h40 || bus.branch_count_out !== 8'h04) begin
        n_fail++; $display("FAIL halted_frozen: got state=%0d pc=%h cnt=%h want 3 40 04", bus.state_out, bus.pc_in, bus.branch_count_out); end
      tick();
    end
    drive(1, 0, 0, 8'h00, 0);
    n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halt_reset outputs: got %h want %h", act_v, exp_v); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'h00, 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halt_recover outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.state_out !== 2'(i) || bus.pc_in !== RV + 8'(i) || bus.branch_count_out !== 8'h00) begin
        n_fail++; $display("FAIL halt_recover: got state=%0d pc=%h cnt=%h want %0d %h 00", bus.state_out, bus.pc_in, bus.branch_count_out, i, RV + 8'(i)); end
      tick();
    end
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 256; b++) begin
      drive(0, 0, 1, 8'($urandom), 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL wrap branch outputs: got %h want %h", act_v, exp_v); end
      tick();
      for (int i = 0; i < FC; i++) begin
        drive(0, 0, 0, 8'h00, 0);
        n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL wrap flush outputs: got %h want %h", act_v, exp_v); end
        tick();
      end
      if (b == 254) begin
        n_chk++; if (bus.branch_count_out !== 8'hff) begin n_fail++; $display("FAIL count_ff: got %h want ff", bus.branch_count_out); end
      end
    end
    n_chk++; if (bus.branch_count_out !== 8'h00) begin n_fail++; $display("FAIL count_wrap: got %h want 00", bus.branch_count_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            8'($urandom), $urandom_range(0, 59) == 0);
      n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL random outputs: got %h want %h", act_v, exp_v); end
      n_chk++; if (bus.pc_in !== m_pc) begin n_fail++; $display("FAIL random pc: got %h want %h", bus.pc_in, m_pc); end
      tick();
    end
  endtask

  initial begin
    bus.pc_in = 8'h00; bus.stall_in = 1'b0; bus.branch_req_in = 1'b0;
    bus.branch_addr_in = 8'h00; bus.halt_in = 1'b0;
    m_boot = 1; m_halt = 0; m_fr = 0; m_cnt = 8'h00; m_pc = 8'h00;
    @(negedge clk);
    test_reset();
    test_branch();
    test_stall();
    test_flush_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
